// File: rtl/rrd_uop_rx_queue_if.sv
// rrd_uop_rx_queue_if: the register-read-decode to ALU micro-op hand-off.
// It carries the micro-op handshake, the head presentation to execute,
// and the branch-update and flush broadcasts.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds its offer until it sees ready.
// in_ready depends only on registered queue state. out_valid may drop
// combinationally in the same cycle when the head is killed.
interface rrd_uop_rx_queue_if #(
  parameter int PAYLOAD_W = 57,
  parameter int BR_W      = 20
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BR_W-1:0]      in_br_mask;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [BR_W-1:0]      out_br_mask;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [BR_W-1:0]      brupdate_resolve_mask;
  logic [BR_W-1:0]      brupdate_mispredict_mask;
  logic                 flush;

  modport master (
    output in_valid, in_br_mask, in_payload, out_ready,
           brupdate_resolve_mask, brupdate_mispredict_mask, flush,
    input  in_ready, out_valid, out_br_mask, out_payload
  );

  modport slave (
    input  in_valid, in_br_mask, in_payload, out_ready,
           brupdate_resolve_mask, brupdate_mispredict_mask, flush,
    output in_ready, out_valid, out_br_mask, out_payload
  );
endinterface

// File: rtl/rrd_uop_rx_queue.sv
// rrd_uop_rx_queue: a small collapsing queue of decoded micro-ops in front
// of ALU execute. It keeps branch masks current and kills entries on a
// mispredict or a flush.
// Optional feature: define RRD_UOP_RX_KILL_CNT_EN to add a saturating
// 16-bit kill_count output. It counts killed entries plus dropped incoming
// micro-ops.
module rrd_uop_rx_queue #(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 57,
  parameter int BR_W      = 20
) (
  input  logic              clock,
  input  logic              reset,
  rrd_uop_rx_queue_if.slave q
`ifdef RRD_UOP_RX_KILL_CNT_EN
  ,
  output logic [15:0]       kill_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     valid_r;
  logic [BR_W-1:0]      mask_r    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_r [DEPTH];

  logic [DEPTH-1:0]     kill;
  logic [DEPTH-1:0]     keep;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     pos       [DEPTH];
  logic [CNT_W-1:0]     run;
  logic [CNT_W-1:0]     n_keep;
  logic                 in_hit;
  logic                 enq;
  logic                 enq_store;
  logic                 enq_drop;
  logic                 deq;

  logic [DEPTH-1:0]     n_valid;
  logic [BR_W-1:0]      n_mask    [DEPTH];
  logic [PAYLOAD_W-1:0] n_payload [DEPTH];

  // Occupancy and the kill vector for this cycle.
  // The queue is always collapsed, so occupancy equals the number of valid
  // entries.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count   = count + CNT_W'(valid_r[i]);
      kill[i] = valid_r[i] &
                (q.flush | (|(mask_r[i] & q.brupdate_mispredict_mask)));
    end
  end

  assign q.in_ready    = (count < CNT_W'(DEPTH));
  assign in_hit        = |(q.in_br_mask & q.brupdate_mispredict_mask);
  assign enq           = q.in_valid & q.in_ready;
  assign enq_store     = enq & ~q.flush & ~in_hit;
  assign enq_drop      = enq & ~enq_store;

  assign q.out_valid   = valid_r[0] & ~kill[0];
  assign q.out_payload = payload_r[0];
  assign q.out_br_mask = mask_r[0] & ~q.brupdate_resolve_mask;
  assign deq           = q.out_valid & q.out_ready;

  // Survivors are valid entries that are not killed and not leaving via
  // the head.
  always_comb begin
    keep    = valid_r & ~kill;
    keep[0] = keep[0] & ~deq;
  end

  // Destination slot of each survivor is the number of survivors older
  // than it.
  always_comb begin
    run = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pos[i] = run;
      run    = run + CNT_W'(keep[i]);
    end
    n_keep = run;
  end

  // Build the collapsed next-state image.
  // Survivors come first, followed by any stored micro-op.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      n_valid[j]   = 1'b0;
      n_mask[j]    = mask_r[j];
      n_payload[j] = payload_r[j];
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && pos[i] == CNT_W'(j)) begin
          n_valid[j]   = 1'b1;
          n_mask[j]    = mask_r[i] & ~q.brupdate_resolve_mask;
          n_payload[j] = payload_r[i];
        end
      end
      if (enq_store && n_keep == CNT_W'(j)) begin
        n_valid[j]   = 1'b1;
        n_mask[j]    = q.in_br_mask & ~q.brupdate_resolve_mask;
        n_payload[j] = q.in_payload;
      end
    end
  end

  // Queue storage: an asynchronous reset clears everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_r[i]    <= '0;
        payload_r[i] <= '0;
      end
    end else begin
      valid_r <= n_valid;
      for (int i = 0; i < DEPTH; i++) begin
        mask_r[i]    <= n_mask[i];
        payload_r[i] <= n_payload[i];
      end
    end
  end

`ifdef RRD_UOP_RX_KILL_CNT_EN
  logic [3:0]  kill_n;
  logic [16:0] kill_sum;

  // Number of entries killed plus any dropped incoming micro-op this cycle.
  always_comb begin
    kill_n = 4'(enq_drop);
    for (int i = 0; i < DEPTH; i++) begin
      kill_n = kill_n + 4'(kill[i]);
    end
    kill_sum = {1'b0, kill_count} + 17'(kill_n);
  end

  // Saturating kill counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kill_count <= '0;
    end else begin
      kill_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_rrd_uop_rx_queue.sv
// tb_rrd_uop_rx_queue: directed bench for rrd_uop_rx_queue.
// A queue-level reference model predicts outputs every cycle. Hand-computed
// literal checks pin the key scenarios.
module tb_rrd_uop_rx_queue;
  localparam int DEPTH     = 2;
  localparam int PAYLOAD_W = 57;
  localparam int BR_W      = 20;
  localparam int ENT_W     = BR_W + PAYLOAD_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rrd_uop_rx_queue_if #(.PAYLOAD_W(PAYLOAD_W), .BR_W(BR_W)) bus ();

`ifdef RRD_UOP_RX_KILL_CNT_EN
  logic [15:0] kill_count;
`endif

  rrd_uop_rx_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .BR_W(BR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .q          (bus)
`ifdef RRD_UOP_RX_KILL_CNT_EN
    ,
    .kill_count (kill_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each entry is {br_mask, payload}, oldest first.
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] nxt_q[$];
  int               m_kill;

  function automatic logic [BR_W-1:0] ent_mask(input logic [ENT_W-1:0] e);
    return e[ENT_W-1:PAYLOAD_W];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] ent_pay(input logic [ENT_W-1:0] e);
    return e[PAYLOAD_W-1:0];
  endfunction

  function automatic logic is_killed(input logic [BR_W-1:0] m);
    return bus.flush || ((m & bus.brupdate_mispredict_mask) != '0);
  endfunction

  // Advance the model at each clock edge, or clear it on reset.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_kill = 0;
    end else begin
      int  killed;
      logic head_deq;
      killed   = 0;
      head_deq = (exp_q.size() > 0) && !is_killed(ent_mask(exp_q[0])) && bus.out_ready;
      nxt_q.delete();
      foreach (exp_q[i]) begin
        if (is_killed(ent_mask(exp_q[i]))) killed++;
        else if (!(i == 0 && head_deq))
          nxt_q.push_back({ent_mask(exp_q[i]) & ~bus.brupdate_resolve_mask, ent_pay(exp_q[i])});
      end
      if (bus.in_valid && exp_q.size() < DEPTH) begin
        if (is_killed(bus.in_br_mask)) killed++;
        else nxt_q.push_back({bus.in_br_mask & ~bus.brupdate_resolve_mask, bus.in_payload});
      end
      exp_q  = nxt_q;
      m_kill = (m_kill + killed > 65535) ? 65535 : m_kill + killed;
    end
  end

  // Compare the DUT outputs against the model mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    end else begin
      logic exp_valid;
      exp_valid = (exp_q.size() > 0) && !is_killed(ent_mask(exp_q[0]));
      check("m_in_ready", 64'(bus.in_ready), 64'(exp_q.size() < DEPTH));
      check("m_out_valid", 64'(bus.out_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("m_out_payload", 64'(bus.out_payload), 64'(ent_pay(exp_q[0])));
        check("m_out_br_mask", 64'(bus.out_br_mask),
              64'(ent_mask(exp_q[0]) & ~bus.brupdate_resolve_mask));
      end
`ifdef RRD_UOP_RX_KILL_CNT_EN
      check("m_kill_count", 64'(kill_count), 64'(m_kill));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic iv, input logic [BR_W-1:0] m, input logic [PAYLOAD_W-1:0] p,
                     input logic ordy, input logic [BR_W-1:0] res, input logic [BR_W-1:0] misp,
                     input logic fl);
    @(posedge clock);
    #1;
    bus.in_valid                 = iv;
    bus.in_br_mask               = m;
    bus.in_payload               = p;
    bus.out_ready                = ordy;
    bus.brupdate_resolve_mask    = res;
    bus.brupdate_mispredict_mask = misp;
    bus.flush                    = fl;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, '0, ordy, '0, '0, 1'b0);
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.in_valid = 0; bus.in_br_mask = '0; bus.in_payload = '0; bus.out_ready = 0;
    bus.brupdate_resolve_mask = '0; bus.brupdate_mispredict_mask = '0; bus.flush = 0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_payload", 64'(bus.out_payload), 64'd0);
    check("reset_out_br_mask", 64'(bus.out_br_mask), 64'd0);
    @(posedge clock);
    #2 reset = 1;

    // Single micro-op, 1-cycle latency.
    cyc(1, '0, 57'h123, 1, '0, '0, 0);
    mid();
    check("t1_in_ready_accept", 64'(bus.in_ready), 64'd1);
    idle(1);
    mid();
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_payload", 64'(bus.out_payload), 64'h123);
    check("t1_in_ready", 64'(bus.in_ready), 64'd1);

    // Fill to full under back-pressure, then drain in order.
    cyc(1, '0, 57'hA, 0, '0, '0, 0);
    cyc(1, '0, 57'hB, 0, '0, '0, 0);
    idle(0);
    mid();
    check("t2_full_in_ready", 64'(bus.in_ready), 64'd0);
    check("t2_head_a_stall", 64'(bus.out_payload), 64'hA);
    idle(1);
    mid();
    check("t2_drain_a_valid", 64'(bus.out_valid), 64'd1);
    check("t2_drain_a", 64'(bus.out_payload), 64'hA);
    idle(1);
    mid();
    check("t2_drain_b", 64'(bus.out_payload), 64'hB);
    idle(1);
    mid();
    check("t2_empty", 64'(bus.out_valid), 64'd0);

    // Mispredict kills the head; B moves up.
    cyc(1, 20'h00001, 57'hA, 0, '0, '0, 0);
    cyc(1, 20'h00002, 57'hB, 0, '0, '0, 0);
    cyc(0, '0, '0, 0, 20'h00001, 20'h00001, 0);
    mid();
    check("t3_killed_head", 64'(bus.out_valid), 64'd0);
    idle(0);
    mid();
    check("t3_b_valid", 64'(bus.out_valid), 64'd1);
    check("t3_b_payload", 64'(bus.out_payload), 64'hB);
    check("t3_b_mask", 64'(bus.out_br_mask), 64'h00002);

    // Resolve clears a bit both combinationally and in storage.
    cyc(0, '0, '0, 0, '0, '0, 1);
    mid();
    check("t4_flush_head", 64'(bus.out_valid), 64'd0);
    cyc(1, 20'h00003, 57'hA, 0, '0, '0, 0);
    cyc(0, '0, '0, 0, 20'h00001, '0, 0);
    mid();
    check("t4_same_cycle_mask", 64'(bus.out_br_mask), 64'h00002);
    idle(0);
    mid();
    check("t4_stored_mask", 64'(bus.out_br_mask), 64'h00002);

    // Asynchronous reset in the middle of operation.
    cyc(1, '0, 57'hB, 0, '0, '0, 0);
    idle(0);
    mid();
    check("t5_pre_reset_full", 64'(bus.in_ready), 64'd0);
    reset = 0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clock);
    #2 reset = 1;

    // Flush while full with an incoming offer.
    cyc(1, '0, 57'hA, 0, '0, '0, 0);
    cyc(1, '0, 57'hB, 0, '0, '0, 0);
    cyc(1, '0, 57'hC, 0, '0, '0, 1);
    mid();
    check("t5_flush_out_valid", 64'(bus.out_valid), 64'd0);
    idle(0);
    mid();
    check("t5_after_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t5_after_flush_ready", 64'(bus.in_ready), 64'd1);
`ifdef RRD_UOP_RX_KILL_CNT_EN
    check("t5_kill_count", 64'(kill_count), 64'd2);
`endif

    // Incoming micro-op dropped by a same-cycle mispredict.
    cyc(1, 20'h00004, 57'hC, 0, 20'h00004, 20'h00004, 0);
    mid();
    check("t6_no_present_now", 64'(bus.out_valid), 64'd0);
    idle(0);
    mid();
    check("t6_never_presented", 64'(bus.out_valid), 64'd0);
    check("t6_ready", 64'(bus.in_ready), 64'd1);
`ifdef RRD_UOP_RX_KILL_CNT_EN
    check("t6_kill_count", 64'(kill_count), 64'd3);
`endif

    // Mixed directed pattern; the model checks every cycle.
    for (int k = 0; k < 48; k++) begin
      logic [BR_W-1:0] m, res, misp;
      m    = BR_W'(1) << (k % 4);
      res  = (k % 7 == 3) ? (BR_W'(1) << (k % 4)) : '0;
      misp = (k % 11 == 5) ? res : '0;
      cyc((k % 3) != 2, m, PAYLOAD_W'(k * 17 + 1), (k % 5) < 3, res, misp, k == 29);
    end
    idle(1);
    repeat (3) @(posedge clock);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
